// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with debounce, key pulse and 8-digit code history
module keypad_scanner #(
  parameter int SCAN_DIV       = 10,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] digits
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);
  state_t state_q, state_d;
  logic [SCAN_DIV-1:0] div_q, div_d;
  logic [3:0] sync_q, sync_d, rs_q, rs_d, cnt_q, cnt_d, cnt_inc, key_code_q, key_code_d;
  logic [1:0] col_idx_q, col_idx_d, r_q, r_d, c_q, c_d, hit_row;
  logic key_valid_q, key_valid_d, key_held_q, key_held_d, tick, hit, same_row;
  logic [31:0] digits_q, digits_d;
  assign tick = &div_q;
  assign hit = ~&rs_q;
  assign hit_row = !rs_q[0] ? 2'd0 : !rs_q[1] ? 2'd1 : !rs_q[2] ? 2'd2 : 2'd3;
  assign same_row = hit && hit_row == r_q;
  assign cnt_inc = cnt_q == DS ? cnt_q : cnt_q + 4'd1;
  assign col = ~(4'b1 << col_idx_q);
  assign key_code = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held = key_held_q;
  assign digits = digits_q;
  always_comb begin
    sync_d = row;
    rs_d = sync_q;
    div_d = div_q + 1'b1;
    state_d = state_q;
    col_idx_d = col_idx_q;
    cnt_d = cnt_q;
    r_d = r_q;
    c_d = c_q;
    key_code_d = key_code_q;
    key_valid_d = 1'b0;
    key_held_d = key_held_q;
    digits_d = digits_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (hit) begin
            r_d = hit_row;
            c_d = col_idx_q;
            cnt_d = 4'd1;
            state_d = DEBOUNCE;
          end else col_idx_d = col_idx_q + 2'd1;
        end
        DEBOUNCE: begin
          if (same_row) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS) begin
              state_d = PRESSED;
              key_code_d = {r_q, c_q};
              key_valid_d = 1'b1;
              key_held_d = 1'b1;
              digits_d = {digits_q[27:0], r_q, c_q};
            end
          end else begin
            state_d = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        PRESSED: begin
          if (!hit) begin
            state_d = RELEASE;
            cnt_d = 4'd1;
          end
        end
        RELEASE: begin
          // a renewed hit here is release bounce: resume holding silently
          if (hit) state_d = PRESSED;
          else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS) begin
              state_d = SCAN;
              key_held_d = 1'b0;
              col_idx_d = col_idx_q + 2'd1;
            end
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 4'hF;
      rs_q <= 4'hF;
      div_q <= '0;
      state_q <= SCAN;
      col_idx_q <= 2'd0;
      cnt_q <= 4'd0;
      r_q <= 2'd0;
      c_q <= 2'd0;
      key_code_q <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q <= 1'b0;
      digits_q <= 32'd0;
    end else begin
      sync_q <= sync_d;
      rs_q <= rs_d;
      div_q <= div_d;
      state_q <= state_d;
      col_idx_q <= col_idx_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      c_q <= c_d;
      key_code_q <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q <= key_held_d;
      digits_q <= digits_d;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random key presses against a keypad model and key-history reference
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row, col, key_code;
  logic key_valid, key_held;
  logic [31:0] digits;
  logic [15:0] keys = '0;
  logic [31:0] exp_digits = '0;
  logic [3:0] pulse_code;
  int total = 0, bad = 0, cyc = 0, pulses = 0, pulse_cyc = 0, x0 = 0, p0 = 0;

  keypad_scanner #(.SCAN_DIV(2), .DEBOUNCE_SCANS(4)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .digits(digits)
  );

  always #5 clk = ~clk;

  // physical matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (key_valid) begin
      pulses <= pulses + 1;
      pulse_cyc <= cyc + 1;
      pulse_code <= key_code;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    chk("rst_col", {28'd0, col}, 32'hE);
    chk("rst_digits", digits, 32'd0);
    chk("rst_kv", {31'd0, key_valid}, 32'd0);
    chk("rst_held", {31'd0, key_held}, 32'd0);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    rst = 1'b0;
    x0 = cyc;
    exp_digits = '0;
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    int b;
    b = pulses;
    keys = 16'(1) << code;
    step(4 * hold);
    exp_digits = (exp_digits << 4) | 32'(code);
    chk("press_pulses", 32'(pulses - b), 32'd1);
    chk("press_code", {28'd0, key_code}, {28'd0, code});
    chk("press_pcode", {28'd0, pulse_code}, {28'd0, code});
    chk("press_digits", digits, exp_digits);
    chk("press_held", {31'd0, key_held}, 32'd1);
    keys = '0;
    step(4 * rel);
    chk("release_held", {31'd0, key_held}, 32'd0);
    chk("release_digits", digits, exp_digits);
  endtask

  initial begin
    do_reset();
    for (int t = 1; t <= 16; t++) begin
      step(4);
      chk("idle_col", {28'd0, col}, {28'd0, ~(4'b1 << (t % 4))});
    end
    chk("idle_pulses", 32'(pulses), 32'd0);

    do_reset();
    p0 = pulses;
    keys = 16'h0040;
    step(23);
    chk("clean_early_kv", {31'd0, key_valid}, 32'd0);
    step(1);
    chk("clean_kv", {31'd0, key_valid}, 32'd1);
    chk("clean_code", {28'd0, key_code}, 32'd6);
    chk("clean_digits", digits, 32'h6);
    chk("clean_held", {31'd0, key_held}, 32'd1);
    chk("clean_latency", 32'(pulse_cyc - x0), 32'd24);
    step(1);
    chk("clean_kv_width", {31'd0, key_valid}, 32'd0);
    step(1);
    keys = '0;
    step(8);
    chk("clean_rel_held", {31'd0, key_held}, 32'd1);
    step(12);
    chk("clean_rel_done", {31'd0, key_held}, 32'd0);
    chk("clean_rel_col", {28'd0, col}, 32'h7);
    chk("clean_pulses", 32'(pulses - p0), 32'd1);
    chk("clean_keep_code", {28'd0, key_code}, 32'd6);

    do_reset();
    p0 = pulses;
    keys = 16'h0100;
    step(8);
    keys = '0;
    step(4);
    chk("bounce_col", {28'd0, col}, 32'hD);
    step(24);
    chk("bounce_pulses", 32'(pulses - p0), 32'd0);
    chk("bounce_held", {31'd0, key_held}, 32'd0);

    do_reset();
    p0 = pulses;
    keys = 16'h0100;
    step(18);
    chk("rb_pulses1", 32'(pulses - p0), 32'd1);
    chk("rb_code", {28'd0, key_code}, 32'd8);
    keys = '0;
    step(8);
    keys = 16'h0100;
    step(4);
    chk("rb_held1", {31'd0, key_held}, 32'd1);
    step(20);
    chk("rb_held2", {31'd0, key_held}, 32'd1);
    chk("rb_pulses2", 32'(pulses - p0), 32'd1);
    keys = '0;
    step(28);
    chk("rb_held3", {31'd0, key_held}, 32'd0);
    chk("rb_pulses3", 32'(pulses - p0), 32'd1);
    chk("rb_digits", digits, 32'h8);

    do_reset();
    for (int i = 1; i <= 9; i++) press(4'(i), 14, 8);
    chk("seq_digits", digits, 32'h23456789);

    do_reset();
    p0 = pulses;
    keys = 16'h1001;
    step(18);
    chk("multi_pulses", 32'(pulses - p0), 32'd1);
    chk("multi_code", {28'd0, key_code}, 32'd0);
    chk("multi_latency", 32'(pulse_cyc - x0), 32'd16);
    keys = '0;
    step(32);

    press(4'd9, 14, 8);
    p0 = pulses;
    keys = 16'h00F0;
    step(8);
    chk("mid_nopulse", 32'(pulses - p0), 32'd0);
    rst = 1'b1;
    step(1);
    chk("mid_col", {28'd0, col}, 32'hE);
    chk("mid_kv", {31'd0, key_valid}, 32'd0);
    chk("mid_held", {31'd0, key_held}, 32'd0);
    chk("mid_digits", digits, 32'd0);
    chk("mid_code", {28'd0, key_code}, 32'd0);
    step(2);
    rst = 1'b0;
    x0 = cyc;
    exp_digits = 32'h4;
    step(18);
    chk("mid_redetect", 32'(pulses - p0), 32'd1);
    chk("mid_recode", {28'd0, key_code}, 32'd4);
    chk("mid_relatency", 32'(pulse_cyc - x0), 32'd16);
    chk("mid_redigits", digits, exp_digits);
    keys = '0;
    step(32);

    for (int i = 0; i < 20; i++)
      press(4'($urandom_range(0, 15)), int'($urandom_range(12, 18)), int'($urandom_range(8, 10)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
